// File: rtl/pcx_stream_arbiter_if.sv
// Shared-stream handshake bundle: per-core word inputs plus the single arbitrated PCX output.
// The arbiter uses the master modport; the environment that feeds and drains it uses slave.
interface pcx_stream_arbiter_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 2
);
    logic [NUM_CORES-1:0]        core_valid;
    logic [NUM_CORES*DATA_W-1:0] core_data;
    logic [NUM_CORES-1:0]        core_stall;
    logic                        pcx_valid;
    logic                        pcx_stall;
    logic [DATA_W-1:0]           pcx_data;
    logic [ID_W-1:0]             pcx_src;
    logic                        pcx_sop;
    logic                        pcx_eop;

    modport master (
        input  core_valid, core_data, pcx_stall,
        output core_stall, pcx_valid, pcx_data, pcx_src, pcx_sop, pcx_eop
    );

    modport slave (
        output core_valid, core_data, pcx_stall,
        input  core_stall, pcx_valid, pcx_data, pcx_src, pcx_sop, pcx_eop
    );
endinterface

// File: rtl/pcx_stream_arbiter.sv
// Round-robin arbiter that merges per-core PCX word streams onto one registered output stream.
// A grant is held for a whole fixed-length packet, so packets from different cores never interleave.
module pcx_stream_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PKT_WORDS = 4,
    parameter int unsigned ID_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] core_en,
    pcx_stream_arbiter_if.master bus,
    output logic                 busy
);
    localparam int unsigned CNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [ID_W-1:0]  LAST_RESET = ID_W'(NUM_CORES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PKT_WORDS - 1);

    logic [0:0]        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   src_q, src_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;

    // Round-robin pick: rotate candidates so bit 0 is last_grant+1, then take the lowest set bit.
    logic [NUM_CORES-1:0]   cand;
    logic [NUM_CORES-1:0]   cand_rot;
    logic [2*NUM_CORES-1:0] cand_dbl;
    logic [ID_W:0]          start;
    logic [ID_W:0]          offset;
    logic [ID_W+1:0]        sum;
    logic [ID_W-1:0]        sel;

    assign cand     = bus.core_valid & core_en;
    assign cand_dbl = {cand, cand};
    assign start    = {1'b0, last_grant_q} + (ID_W+1)'(1);
    assign cand_rot = NUM_CORES'(cand_dbl >> start);

    always_comb begin
        offset = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (cand_rot[k]) offset = (ID_W+1)'(k);
        end
    end

    assign sum = (ID_W+2)'(start) + (ID_W+2)'(offset);
    assign sel = (sum >= (ID_W+2)'(NUM_CORES)) ? ID_W'(sum - (ID_W+2)'(NUM_CORES)) : ID_W'(sum);

    logic              g_valid;
    logic [DATA_W-1:0] g_data;

    always_comb begin
        g_valid = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_q == ID_W'(i)) begin
                g_valid = bus.core_valid[i];
                g_data  = bus.core_data[i*DATA_W +: DATA_W];
            end
        end
    end

    logic load;
    logic out_xfer;
    logic in_xfer;

    assign load     = ~valid_q | ~bus.pcx_stall;
    assign out_xfer = valid_q & ~bus.pcx_stall;
    assign in_xfer  = (state_q == ST_BURST) & load & g_valid;

    // Only the granted core may see its stall released, and only while the output can load.
    logic [NUM_CORES-1:0] stall;

    always_comb begin
        stall = '1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (state_q == ST_BURST && grant_q == ID_W'(i)) stall[i] = ~load;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        data_d       = data_q;
        src_d        = src_q;
        sop_d        = sop_q;
        eop_d        = eop_q;

        case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    cnt_d        = '0;
                    state_d      = ST_BURST;
                end
            end
            ST_BURST: begin
                if (in_xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = g_data;
            src_d   = grant_q;
            sop_d   = (cnt_q == '0);
            eop_d   = (cnt_q == CNT_LAST);
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RESET;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            src_q        <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            src_q        <= src_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
        end
    end

    assign bus.core_stall = stall;
    assign bus.pcx_valid  = valid_q;
    assign bus.pcx_data   = data_q;
    assign bus.pcx_src    = src_q;
    assign bus.pcx_sop    = sop_q;
    assign bus.pcx_eop    = eop_q;
    assign busy           = (state_q == ST_BURST) | valid_q;
endmodule

// File: tb/tb_pcx_stream_arbiter.sv
// Bench for pcx_stream_arbiter: directed packet scenarios followed by randomized traffic
// checked against a packet-level round-robin model.
module tb_pcx_stream_arbiter;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int PW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] core_en;
    logic          busy;

    pcx_stream_arbiter_if #(.NUM_CORES(NC), .DATA_W(DW), .ID_W(IW)) bus ();

    pcx_stream_arbiter #(
        .NUM_CORES(NC),
        .DATA_W   (DW),
        .PKT_WORDS(PW),
        .ID_W     (IW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .core_en(core_en),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [DW-1:0] src_q [NC][$];
    bit            hold  [NC];
    int            acc   [NC];

    logic          s_valid, s_sop, s_eop, s_ofire;
    logic [DW-1:0] s_data;
    logic [IW-1:0] s_src;
    logic [NC-1:0] s_cstall, s_fire;

    logic [DW-1:0] o_data [$];
    int            o_src  [$];
    bit            o_sop  [$];
    bit            o_eop  [$];
    int            o_cyc  [$];

    // Packet-level model state for the randomized rounds.
    bit            rnd_on = 1'b0;
    logic [NC-1:0] en_m;
    int            rem_in  [NC];
    int            rem_out [NC];
    logic [DW-1:0] exp_q   [NC][$];
    int            in_cur, out_cur, in_widx, out_widx, out_done;
    bit            prev_held;
    logic [DW-1:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_core(input int prev, input int r [NC]);
        for (int k = 1; k <= NC; k++) begin
            if (en_m[(prev + k) % NC] && r[(prev + k) % NC] > 0) return (prev + k) % NC;
        end
        return -1;
    endfunction

    task automatic model_check();
        for (int j = 0; j < NC; j++) begin
            if (j != in_cur) chk("rnd_nongrant_stall", 32'(s_cstall[j]), 32'd1);
        end
        if (prev_held) begin
            chk("rnd_hold_valid", 32'(s_valid), 32'd1);
            chk("rnd_hold_data", s_data, prev_data);
        end
        if (s_ofire) begin
            if (out_cur >= 0 && exp_q[out_cur].size() > 0) begin
                chk("rnd_src", 32'(s_src), 32'(out_cur));
                chk("rnd_data", s_data, exp_q[out_cur].pop_front());
                chk("rnd_sop", 32'(s_sop), 32'(out_widx == 0));
                chk("rnd_eop", 32'(s_eop), 32'(out_widx == PW - 1));
                out_done++;
                out_widx++;
                if (out_widx == PW) begin
                    out_widx = 0;
                    rem_out[out_cur]--;
                    out_cur = next_core(out_cur, rem_out);
                end
            end else begin
                chk("rnd_unexpected_word", 32'(s_ofire), 32'd0);
            end
        end
        if (in_cur >= 0 && s_fire[in_cur]) begin
            in_widx++;
            if (in_widx == PW) begin
                in_widx = 0;
                rem_in[in_cur]--;
                in_cur = next_core(in_cur, rem_in);
            end
        end
        prev_held = s_valid && bus.pcx_stall;
        prev_data = s_data;
    endtask

    // One clock period: drive sources, sample at negedge, retire accepted words after the edge.
    task automatic cyc();
        for (int i = 0; i < NC; i++) begin
            bus.core_valid[i]         = (src_q[i].size() > 0) && !hold[i];
            bus.core_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
        @(negedge clk);
        s_valid  = bus.pcx_valid;
        s_data   = bus.pcx_data;
        s_src    = bus.pcx_src;
        s_sop    = bus.pcx_sop;
        s_eop    = bus.pcx_eop;
        s_cstall = bus.core_stall;
        s_fire   = bus.core_valid & ~bus.core_stall;
        s_ofire  = bus.pcx_valid & ~bus.pcx_stall;
        if (s_ofire) begin
            o_data.push_back(s_data);
            o_src.push_back(int'(s_src));
            o_sop.push_back(s_sop);
            o_eop.push_back(s_eop);
            o_cyc.push_back(cycle);
        end
        if (rnd_on) model_check();
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (s_fire[i]) begin
                void'(src_q[i].pop_front());
                acc[i]++;
            end
        end
        cycle++;
    endtask

    task automatic clear_tb();
        for (int i = 0; i < NC; i++) begin
            src_q[i].delete();
            hold[i] = 1'b0;
            acc[i]  = 0;
        end
        o_data.delete();
        o_src.delete();
        o_sop.delete();
        o_eop.delete();
        o_cyc.delete();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.pcx_stall  = 1'b0;
        bus.core_valid = '0;
        bus.core_data  = '0;
        core_en        = '1;
        en_m           = '1;
        clear_tb();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_pkts(input int core, input int npkt);
        for (int p = 0; p < npkt; p++) begin
            for (int w = 0; w < PW; w++) src_q[core].push_back({8'(core), 8'(p), 16'(w)});
        end
    endtask

    initial begin
        int            c0;
        int            n1;
        int            ord [5];
        logic [DW-1:0] w4 [4];
        bit            cleared;
        int            expected;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(bus.pcx_valid), 32'd0);
        chk("rst_data", bus.pcx_data, 32'd0);
        chk("rst_src", 32'(bus.pcx_src), 32'd0);
        chk("rst_sop", 32'(bus.pcx_sop), 32'd0);
        chk("rst_eop", 32'(bus.pcx_eop), 32'd0);
        chk("rst_core_stall", 32'(bus.core_stall), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single packet from core 1
        w4 = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int w = 0; w < PW; w++) src_q[1].push_back(w4[w]);
        c0 = cycle;
        repeat (10) cyc();
        chk("t1_count", 32'(o_data.size()), 32'd4);
        for (int k = 0; k < PW; k++) begin
            if (k < o_data.size()) begin
                chk("t1_data", o_data[k], w4[k]);
                chk("t1_src", 32'(o_src[k]), 32'd1);
                chk("t1_sop", 32'(o_sop[k]), 32'(k == 0));
                chk("t1_eop", 32'(o_eop[k]), 32'(k == PW - 1));
                chk("t1_cycle", 32'(o_cyc[k]), 32'(c0 + 2 + k));
            end
        end

        // Round-robin with all cores continuously valid
        do_reset();
        for (int c = 0; c < NC; c++) push_pkts(c, 2);
        repeat (40) cyc();
        chk("t2_enough", 32'(o_data.size() >= 20), 32'd1);
        ord = '{0, 1, 2, 3, 0};
        for (int n = 0; n < 5; n++) begin
            for (int w = 0; w < PW; w++) begin
                if (n * PW + w < o_data.size()) begin
                    chk("t2_src", 32'(o_src[n*PW+w]), 32'(ord[n]));
                    chk("t2_data", o_data[n*PW+w], {8'(ord[n]), 8'(n / 4), 16'(w)});
                    chk("t2_contig", 32'(o_cyc[n*PW+w]), 32'(o_cyc[n*PW] + w));
                end
            end
            if ((n + 1) * PW < o_data.size())
                chk("t2_bubble", 32'(o_cyc[(n+1)*PW]), 32'(o_cyc[n*PW+PW-1] + 2));
        end

        // Backpressure while the second word sits in the output register
        do_reset();
        w4 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        for (int w = 0; w < PW; w++) src_q[2].push_back(w4[w]);
        repeat (3) cyc();
        bus.pcx_stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("t3_hold_valid", 32'(s_valid), 32'd1);
            chk("t3_hold_data", s_data, w4[1]);
            chk("t3_core_stall", 32'(s_cstall[2]), 32'd1);
        end
        bus.pcx_stall = 1'b0;
        repeat (8) cyc();
        chk("t3_count", 32'(o_data.size()), 32'd4);
        for (int k = 0; k < PW; k++) begin
            if (k < o_data.size()) begin
                chk("t3_data", o_data[k], w4[k]);
                chk("t3_eop", 32'(o_eop[k]), 32'(k == PW - 1));
            end
        end

        // Enable masking, core 2 disabled mid-packet
        do_reset();
        core_en = 4'b1101;
        for (int c = 0; c < NC; c++) push_pkts(c, 2);
        cleared = 1'b0;
        repeat (60) begin
            cyc();
            if (!cleared && s_valid && s_src == 2'd2) begin
                core_en[2] = 1'b0;
                cleared    = 1'b1;
            end
        end
        chk("t4_count", 32'(o_data.size()), 32'd20);
        ord = '{0, 2, 3, 0, 3};
        n1  = 0;
        for (int i = 0; i < o_data.size(); i++) if (o_src[i] == 1) n1++;
        chk("t4_core1_words", 32'(n1), 32'd0);
        for (int n = 0; n < 5; n++) begin
            for (int w = 0; w < PW; w++) begin
                if (n * PW + w < o_data.size()) begin
                    chk("t4_src", 32'(o_src[n*PW+w]), 32'(ord[n]));
                    chk("t4_eop", 32'(o_eop[n*PW+w]), 32'(w == PW - 1));
                end
            end
        end

        // Source bubble: core 0 drops valid for 5 cycles after two words
        do_reset();
        push_pkts(0, 1);
        push_pkts(1, 1);
        for (int t = 0; t < 20 && acc[0] < 2; t++) cyc();
        chk("t5_two_words", 32'(acc[0]), 32'd2);
        hold[0] = 1'b1;
        for (int h = 0; h < 5; h++) begin
            cyc();
            if (h >= 1) chk("t5_gap_valid", 32'(s_valid), 32'd0);
            chk("t5_gap_others", 32'(s_cstall[3:1]), 32'h7);
            chk("t5_gap_fire", 32'(s_fire), 32'd0);
        end
        hold[0] = 1'b0;
        repeat (15) cyc();
        chk("t5_count", 32'(o_data.size()), 32'd8);
        for (int k = 0; k < 2 * PW; k++) begin
            if (k < o_data.size()) begin
                chk("t5_src", 32'(o_src[k]), 32'(k / PW));
                chk("t5_data", o_data[k], {8'(k / PW), 8'd0, 16'(k % PW)});
                chk("t5_sop", 32'(o_sop[k]), 32'(k % PW == 0));
            end
        end

        // Reset in the middle of a packet
        do_reset();
        push_pkts(0, 1);
        for (int t = 0; t < 20 && acc[0] < 2; t++) cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus.pcx_valid), 32'd0);
        chk("t6_rst_core_stall", 32'(bus.core_stall), 32'hF);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        clear_tb();
        w4 = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        for (int w = 0; w < PW; w++) src_q[0].push_back(w4[w]);
        push_pkts(1, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) cyc();
        chk("t6_count", 32'(o_data.size()), 32'd8);
        if (o_data.size() > 0) begin
            chk("t6_first_src", 32'(o_src[0]), 32'd0);
            chk("t6_first_sop", 32'(o_sop[0]), 32'd1);
            chk("t6_first_data", o_data[0], w4[0]);
        end

        // Randomized traffic against the packet-level model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            en_m     = 4'($urandom_range(1, 15));
            core_en  = en_m;
            expected = 0;
            for (int c = 0; c < NC; c++) begin
                int np;
                np = int'($urandom_range(2, 4));
                exp_q[c].delete();
                for (int i = 0; i < np * PW; i++) begin
                    logic [DW-1:0] wd;
                    wd = $urandom;
                    src_q[c].push_back(wd);
                    if (en_m[c]) exp_q[c].push_back(wd);
                end
                rem_in[c]  = en_m[c] ? np : 0;
                rem_out[c] = rem_in[c];
                if (en_m[c]) expected += np * PW;
            end
            in_cur    = next_core(NC - 1, rem_in);
            out_cur   = in_cur;
            in_widx   = 0;
            out_widx  = 0;
            out_done  = 0;
            prev_held = 1'b0;
            rnd_on    = 1'b1;
            for (int t = 0; t < 3000 && out_done < expected; t++) begin
                bus.pcx_stall = ($urandom_range(0, 9) < 3);
                for (int c = 0; c < NC; c++) hold[c] = 1'b0;
                if (in_cur >= 0 && in_widx != 0) hold[in_cur] = ($urandom_range(0, 3) == 0);
                cyc();
            end
            rnd_on = 1'b0;
            chk("rnd_complete", 32'(out_done), 32'(expected));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
